// File: rtl/floo_vc_pkg.sv
// Shared types and the round-robin pick helper for the FlooNoC VC arbitration mux.
package floo_vc_pkg;

    localparam int unsigned MaxVcs = 32;

    typedef logic [4:0] vc_id_t;

    typedef enum logic {
        LockIdle   = 1'b0,
        LockLocked = 1'b1
    } lock_state_e;

    // Lowest requesting index at or above ptr, wrapping at num_vcs; returns ptr when req is empty.
    function automatic vc_id_t rr_next(input vc_id_t ptr, input logic [MaxVcs-1:0] req,
                                       input int unsigned num_vcs);
        vc_id_t      winner;
        logic        found;
        int unsigned idx;
        winner = ptr;
        found  = 1'b0;
        for (int unsigned i = 0; i < MaxVcs; i++) begin
            if (i < num_vcs) begin
                idx = {27'd0, ptr} + i;
                if (idx >= num_vcs) begin
                    idx = idx - num_vcs;
                end
                if (!found && req[idx[4:0]]) begin
                    winner = vc_id_t'(idx);
                    found  = 1'b1;
                end
            end
        end
        return winner;
    endfunction

endpackage

// File: rtl/floo_vc_fifo.sv
// Per-VC flit FIFO holding payload plus last flag, with a registered fill count.
module floo_vc_fifo #(
    parameter int unsigned Depth     = 2,
    parameter type         payload_t = logic [31:0],
    localparam int unsigned PtrWidth  = (Depth > 1) ? $clog2(Depth) : 1,
    localparam int unsigned FillWidth = $clog2(Depth + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 push_i,
    input  payload_t             data_i,
    input  logic                 last_i,
    input  logic                 pop_i,
    output payload_t             data_o,
    output logic                 last_o,
    output logic                 full_o,
    output logic                 empty_o,
    output logic [FillWidth-1:0] fill_o
);

    payload_t             mem_data_q [Depth];
    payload_t             mem_data_d [Depth];
    logic [Depth-1:0]     mem_last_q, mem_last_d;
    logic [PtrWidth-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrWidth-1:0]  rd_ptr_q, rd_ptr_d;
    logic [FillWidth-1:0] fill_q, fill_d;
    logic                 push_ok, pop_ok;

    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
        return (p == PtrWidth'(Depth - 1)) ? '0 : p + PtrWidth'(1);
    endfunction

    assign full_o  = (fill_q == FillWidth'(Depth));
    assign empty_o = (fill_q == '0);
    assign fill_o  = fill_q;
    assign data_o  = mem_data_q[rd_ptr_q];
    assign last_o  = mem_last_q[rd_ptr_q];
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        mem_data_d = mem_data_q;
        mem_last_d = mem_last_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fill_d     = fill_q;
        if (push_ok) begin
            mem_data_d[wr_ptr_q] = data_i;
            mem_last_d[wr_ptr_q] = last_i;
            wr_ptr_d             = ptr_inc(wr_ptr_q);
        end
        if (pop_ok) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (push_ok && !pop_ok) begin
            fill_d = fill_q + FillWidth'(1);
        end else if (!push_ok && pop_ok) begin
            fill_d = fill_q - FillWidth'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                mem_data_q[i] <= '0;
            end
            mem_last_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fill_q     <= '0;
        end else begin
            mem_data_q <= mem_data_d;
            mem_last_q <= mem_last_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fill_q     <= fill_d;
        end
    end

endmodule

// File: rtl/floo_vc_arb_mux.sv
// Per-VC FIFOs feeding a round-robin, optionally packet-locked arbiter into a registered output stage.
module floo_vc_arb_mux
    import floo_vc_pkg::*;
#(
    parameter int unsigned NumVirtChannels = 2,
    parameter int unsigned Depth           = 2,
    parameter int unsigned DataWidth       = 32,
    parameter type         payload_t       = logic [DataWidth-1:0],
    parameter bit          LockPacket      = 1'b1,
    localparam int unsigned VcIdWidth      = (NumVirtChannels > 1) ? $clog2(NumVirtChannels) : 1
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  payload_t [NumVirtChannels-1:0]       data_i,
    input  logic     [NumVirtChannels-1:0]       last_i,
    input  logic     [NumVirtChannels-1:0]       valid_i,
    output logic     [NumVirtChannels-1:0]       ready_o,
    output payload_t                             data_o,
    output logic                                 last_o,
    output logic     [VcIdWidth-1:0]             vc_id_o,
    output logic                                 valid_o,
    input  logic                                 ready_i
);

    localparam int unsigned FillWidth = $clog2(Depth + 1);

    logic [NumVirtChannels-1:0] fifo_empty, fifo_full, fifo_last, push, pop;
    logic [NumVirtChannels-1:0] req, lock_mask;
    payload_t                   fifo_data [NumVirtChannels];
    logic [FillWidth-1:0]       fifo_fill [NumVirtChannels];
    logic [MaxVcs-1:0]          req_ext;
    vc_id_t                     winner;
    logic                       adv, grant;
    payload_t                   win_data;
    logic                       win_last;
    logic [VcIdWidth-1:0]       win_vc;

    payload_t             data_q, data_d;
    logic                 last_q, last_d;
    logic [VcIdWidth-1:0] vc_q, vc_d;
    logic                 valid_q, valid_d;
    vc_id_t               rr_ptr_q, rr_ptr_d;
    lock_state_e          lock_state_q, lock_state_d;
    vc_id_t               lock_vc_q, lock_vc_d;

    for (genvar v = 0; v < NumVirtChannels; v++) begin : gen_vc
        floo_vc_fifo #(
            .Depth     (Depth),
            .payload_t (payload_t)
        ) i_fifo (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .push_i  (push[v]),
            .data_i  (data_i[v]),
            .last_i  (last_i[v]),
            .pop_i   (pop[v]),
            .data_o  (fifo_data[v]),
            .last_o  (fifo_last[v]),
            .full_o  (fifo_full[v]),
            .empty_o (fifo_empty[v]),
            .fill_o  (fifo_fill[v])
        );
        assign ready_o[v]   = (fifo_fill[v] != FillWidth'(Depth));
        assign push[v]      = valid_i[v] && !fifo_full[v];
        assign lock_mask[v] = (lock_vc_q == vc_id_t'(v));
    end

    always_comb begin
        req = ~fifo_empty;
        // While locked only the owning VC may be picked; an empty owner yields a bubble.
        if (LockPacket && (lock_state_q == LockLocked)) begin
            req = req & lock_mask;
        end
        req_ext                        = '0;
        req_ext[NumVirtChannels-1:0]   = req;
        winner                         = rr_next(rr_ptr_q, req_ext, NumVirtChannels);
        adv                            = !valid_q || ready_i;
        grant                          = adv && (|req);

        pop      = '0;
        win_data = '0;
        win_last = 1'b0;
        win_vc   = '0;
        for (int unsigned v = 0; v < NumVirtChannels; v++) begin
            pop[v] = grant && (winner == vc_id_t'(v));
            if (pop[v]) begin
                win_data = fifo_data[v];
                win_last = fifo_last[v];
                win_vc   = VcIdWidth'(v);
            end
        end
    end

    always_comb begin
        data_d       = data_q;
        last_d       = last_q;
        vc_d         = vc_q;
        valid_d      = valid_q;
        rr_ptr_d     = rr_ptr_q;
        lock_state_d = lock_state_q;
        lock_vc_d    = lock_vc_q;
        if (adv) begin
            valid_d = grant;
            if (grant) begin
                data_d = win_data;
                last_d = win_last;
                vc_d   = win_vc;
            end
        end
        if (grant) begin
            rr_ptr_d = (winner == vc_id_t'(NumVirtChannels - 1)) ? '0 : winner + vc_id_t'(1);
        end
        if (LockPacket && grant) begin
            if ((lock_state_q == LockIdle) && !win_last) begin
                lock_state_d = LockLocked;
                lock_vc_d    = winner;
            end else if ((lock_state_q == LockLocked) && win_last) begin
                lock_state_d = LockIdle;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q       <= '0;
            last_q       <= 1'b0;
            vc_q         <= '0;
            valid_q      <= 1'b0;
            rr_ptr_q     <= '0;
            lock_state_q <= LockIdle;
            lock_vc_q    <= '0;
        end else begin
            data_q       <= data_d;
            last_q       <= last_d;
            vc_q         <= vc_d;
            valid_q      <= valid_d;
            rr_ptr_q     <= rr_ptr_d;
            lock_state_q <= lock_state_d;
            lock_vc_q    <= lock_vc_d;
        end
    end

    assign data_o  = data_q;
    assign last_o  = last_q;
    assign vc_id_o = vc_q;
    assign valid_o = valid_q;

endmodule

// File: tb/tb_floo_vc_arb_mux.sv
// Three configurations (locked 4-VC, unlocked 4-VC, single-VC depth-1) checked against a queue-based model.
module tb_floo_vc_arb_mux;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [3:0]       vin [3];
    logic [3:0]       lin [3];
    logic [3:0][31:0] din [3];
    logic             rin [3];

    logic [3:0]  ro0, ro1;
    logic        ro2;
    logic [31:0] do0, do1, do2;
    logic        lo0, lo1, lo2;
    logic [1:0]  vc0, vc1;
    logic        vc2;
    logic        vo0, vo1, vo2;

    floo_vc_arb_mux #(.NumVirtChannels(4), .Depth(2), .DataWidth(32), .LockPacket(1'b1)) u_lock (
        .clk_i(clk), .rst_i(rst), .data_i(din[0]), .last_i(lin[0]), .valid_i(vin[0]),
        .ready_o(ro0), .data_o(do0), .last_o(lo0), .vc_id_o(vc0), .valid_o(vo0), .ready_i(rin[0]));

    floo_vc_arb_mux #(.NumVirtChannels(4), .Depth(2), .DataWidth(32), .LockPacket(1'b0)) u_nolock (
        .clk_i(clk), .rst_i(rst), .data_i(din[1]), .last_i(lin[1]), .valid_i(vin[1]),
        .ready_o(ro1), .data_o(do1), .last_o(lo1), .vc_id_o(vc1), .valid_o(vo1), .ready_i(rin[1]));

    floo_vc_arb_mux #(.NumVirtChannels(1), .Depth(1), .DataWidth(32), .LockPacket(1'b1)) u_single (
        .clk_i(clk), .rst_i(rst), .data_i(din[2][0:0]), .last_i(lin[2][0:0]), .valid_i(vin[2][0:0]),
        .ready_o(ro2), .data_o(do2), .last_o(lo2), .vc_id_o(vc2), .valid_o(vo2), .ready_i(rin[2]));

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: flits as {last, data} in per-VC queues, output register as plain variables.
    int unsigned nvc  [3] = '{4, 4, 1};
    int unsigned mdep [3] = '{2, 2, 1};
    bit          mlk  [3] = '{1'b1, 1'b0, 1'b1};
    logic [32:0] mq [3][4][$];
    bit          mval [3];
    logic [31:0] mdata [3];
    bit          mlast [3];
    int unsigned mvc [3];
    int unsigned mptr [3];
    bit          mlocked [3];
    int unsigned mlockvc [3];
    bit          mloaded [3];

    int          cap_vc   [3][$];
    int          cap_last [3][$];
    logic [31:0] cap_data [3][$];
    int unsigned seq = 0;

    task automatic model_step(input int k);
        bit [3:0]    acc;
        bit          adv, found;
        int unsigned w, v;
        logic [32:0] e;
        acc = '0;
        w   = 0;
        for (int unsigned i = 0; i < nvc[k]; i++)
            acc[i] = vin[k][i] && (mq[k][i].size() < mdep[k]);
        mloaded[k] = 1'b0;
        if (rst) begin
            for (int i = 0; i < 4; i++) mq[k][i].delete();
            mval[k] = 0; mdata[k] = '0; mlast[k] = 0; mvc[k] = 0;
            mptr[k] = 0; mlocked[k] = 0; mlockvc[k] = 0;
            return;
        end
        adv = !mval[k] || rin[k];
        if (adv) begin
            found = 0;
            for (int unsigned i = 0; i < nvc[k]; i++) begin
                v = (mptr[k] + i) % nvc[k];
                if (!found && mq[k][v].size() > 0 && (!(mlk[k] && mlocked[k]) || v == mlockvc[k])) begin
                    w = v;
                    found = 1;
                end
            end
            if (found) begin
                e = mq[k][w].pop_front();
                mval[k] = 1; mdata[k] = e[31:0]; mlast[k] = e[32]; mvc[k] = w;
                mptr[k] = (w + 1) % nvc[k];
                mloaded[k] = 1'b1;
                if (mlk[k]) begin
                    if (!mlocked[k] && !mlast[k]) begin
                        mlocked[k] = 1; mlockvc[k] = w;
                    end else if (mlocked[k] && mlast[k]) begin
                        mlocked[k] = 0;
                    end
                end
            end else begin
                mval[k] = 0;
            end
        end
        for (int unsigned i = 0; i < nvc[k]; i++)
            if (acc[i]) mq[k][i].push_back({lin[k][i], din[k][i]});
    endtask

    function automatic logic [3:0] get_ready(input int k);
        return (k == 0) ? ro0 : (k == 1) ? ro1 : {3'b000, ro2};
    endfunction
    function automatic logic get_valid(input int k);
        return (k == 0) ? vo0 : (k == 1) ? vo1 : vo2;
    endfunction
    function automatic logic [31:0] get_data(input int k);
        return (k == 0) ? do0 : (k == 1) ? do1 : do2;
    endfunction
    function automatic logic get_last(input int k);
        return (k == 0) ? lo0 : (k == 1) ? lo1 : lo2;
    endfunction
    function automatic logic [1:0] get_vc(input int k);
        return (k == 0) ? vc0 : (k == 1) ? vc1 : {1'b0, vc2};
    endfunction

    task automatic check_inst(input int k);
        logic [3:0] er;
        er = '0;
        for (int unsigned i = 0; i < nvc[k]; i++) er[i] = (mq[k][i].size() < mdep[k]);
        check($sformatf("i%0d_ready", k), get_ready(k), er);
        check($sformatf("i%0d_valid", k), get_valid(k), mval[k]);
        if (mval[k]) begin
            check($sformatf("i%0d_data", k), get_data(k), mdata[k]);
            check($sformatf("i%0d_last", k), get_last(k), mlast[k]);
            check($sformatf("i%0d_vcid", k), get_vc(k), mvc[k]);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        for (int k = 0; k < 3; k++) model_step(k);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check_inst(k);
            if (mloaded[k]) begin
                cap_vc[k].push_back(int'(get_vc(k)));
                cap_last[k].push_back(int'(get_last(k)));
                cap_data[k].push_back(get_data(k));
            end
        end
    endtask

    task automatic fresh_data();
        for (int k = 0; k < 3; k++)
            for (int v = 0; v < 4; v++) begin
                din[k][v] = {k[3:0], v[3:0], seq[23:0]};
                seq++;
            end
    endtask

    task automatic idle_all();
        for (int k = 0; k < 3; k++) begin
            vin[k] = '0; lin[k] = '1; rin[k] = 1'b1;
        end
        fresh_data();
    endtask

    task automatic do_reset();
        idle_all();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cap_vc[k].delete(); cap_last[k].delete(); cap_data[k].delete();
        end
    endtask

    initial begin
        int          exp_vc, p, first2, last2, sent [2];
        bit          ok;
        logic [31:0] bp [2][3];

        rst = 1'b1;
        idle_all();
        cycle();
        cycle();
        check("rst_ready", ro0, 4'hF);
        check("rst_valid", vo0, 1'b0);
        check("rst_vcid", vc0, 2'd0);
        check("rst_data", do0, 32'd0);
        check("rst_ready_single", ro2, 1'b1);
        rst = 1'b0;

        // Round robin, all VCs busy, single-flit packets
        do_reset();
        vin[0] = 4'hF; vin[1] = 4'hF;
        exp_vc = 0;
        for (int i = 0; i < 16; i++) begin
            fresh_data();
            cycle();
            if (i >= 1) begin
                check("rr_valid", vo1, 1'b1);
                check("rr_vcid", vc1, exp_vc[1:0]);
                exp_vc = (exp_vc + 1) % 4;
            end
        end

        // VC2 3-flit packet against continuous VC0 traffic
        do_reset();
        sent[0] = 0; sent[1] = 0;
        for (int i = 0; i < 12; i++) begin
            fresh_data();
            for (int k = 0; k < 2; k++) begin
                vin[k] = 4'b0001;
                lin[k] = 4'b1111;
                if (sent[k] < 3) begin
                    vin[k][2] = 1'b1;
                    lin[k][2] = (sent[k] == 2);
                    if (mq[k][2].size() < 2) sent[k]++;
                end
            end
            cycle();
        end
        p = -1;
        for (int i = 0; i < cap_vc[0].size(); i++) if (p < 0 && cap_vc[0][i] == 2) p = i;
        ok = (p >= 0) && (p + 2 < cap_vc[0].size());
        if (ok) ok = (cap_vc[0][p+1] == 2) && (cap_vc[0][p+2] == 2) && (cap_last[0][p+2] == 1);
        check("lock_contig", ok, 1'b1);
        first2 = -1; last2 = -1; ok = 0;
        for (int i = 0; i < cap_vc[1].size(); i++)
            if (cap_vc[1][i] == 2) begin
                if (first2 < 0) first2 = i;
                last2 = i;
            end
        for (int i = 0; i < cap_vc[1].size(); i++)
            if (i > first2 && i < last2 && cap_vc[1][i] == 0) ok = 1;
        check("nolock_interleave", ok, 1'b1);

        // Backpressure: VC1 pushes 3 flits while ready_i is low
        do_reset();
        rin[0] = 1'b0; rin[1] = 1'b0;
        sent[0] = 0; sent[1] = 0;
        for (int k = 0; k < 2; k++)
            for (int j = 0; j < 3; j++) bp[k][j] = 32'hB000_0000 | (k << 8) | j;
        for (int i = 0; i < 5; i++) begin
            for (int k = 0; k < 2; k++) begin
                vin[k] = 4'b0000;
                if (sent[k] < 3) begin
                    vin[k][1] = 1'b1;
                    din[k][1] = bp[k][sent[k]];
                    if (mq[k][1].size() < 2) sent[k]++;
                end
            end
            cycle();
            if (i >= 1) check("bp_data_hold", do0, bp[0][0]);
        end
        check("bp_ready1", ro0[1], 1'b0);
        check("bp_valid", vo0, 1'b1);
        vin[0] = '0; vin[1] = '0;
        rin[0] = 1'b1; rin[1] = 1'b1;
        for (int i = 0; i < 4; i++) cycle();
        check("bp_count", cap_data[0].size(), 3);
        for (int j = 0; j < 3 && j < cap_data[0].size(); j++)
            check($sformatf("bp_order%0d", j), cap_data[0][j], bp[0][j]);

        // Lock on VC3 with its FIFO running dry while VC0 waits
        do_reset();
        vin[0] = 4'b1000; lin[0] = 4'b0111;
        cycle();
        vin[0] = 4'b0001; lin[0] = 4'b1111;
        fresh_data();
        cycle();
        fresh_data();
        cycle();
        check("bubble_a", vo0, 1'b0);
        vin[0] = 4'b1001; lin[0] = 4'b1111;
        fresh_data();
        cycle();
        check("bubble_b", vo0, 1'b0);
        vin[0] = 4'b0001;
        for (int i = 0; i < 6; i++) begin
            fresh_data();
            cycle();
        end
        ok = (cap_vc[0].size() >= 3);
        if (ok) ok = (cap_vc[0][0] == 3) && (cap_vc[0][1] == 3) && (cap_last[0][1] == 1) && (cap_vc[0][2] == 0);
        check("lock_hold_vc3", ok, 1'b1);

        // Random traffic on all three configurations with a reset pulse mid-stream
        do_reset();
        for (int i = 0; i < 1000; i++) begin
            for (int k = 0; k < 3; k++) begin
                vin[k] = 4'($urandom_range(0, 15)) & ((k == 2) ? 4'b0001 : 4'b1111);
                lin[k] = 4'($urandom_range(0, 15)) | 4'($urandom_range(0, 15));
                rin[k] = ($urandom_range(0, 3) != 0);
            end
            fresh_data();
            rst = (i == 500);
            cycle();
            if (i == 500) begin
                check("midrst_valid", vo0, 1'b0);
                check("midrst_ready", ro0, 4'hF);
                check("midrst_ready_single", ro2, 1'b1);
            end
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
